reset_seq: RTL
==============

# reset_seq

Parametrised successor to the terminal's fixed 6-bit power-on reset counter. Combines the external synchronous reset, the front-panel reset button and PLL lock into one sequencer, holds all resets for a programmable time, then releases CHANNELS reset domains one by one with a fixed gap. Sits at the board top level between the PLL and the vt52 core and its peripherals, in the clk50 domain.

## Interface
- CHANNELS, 2: number of reset outputs, 1..8; released in index order.
- HOLD_W, 6: hold counter width; hold time is 2^HOLD_W cycles.
- STAGE_GAP, 16: cycles between successive channel releases, >=1.
- DEB_W, 16: debounce counter width; only used with RESET_SEQ_DEBOUNCE_EN.

- clk50  in  1  system clock, 50 MHz PLL output
- reset  in  1  synchronous, active-high external reset request
- btn_n  in  1  raw reset button, asynchronous, active-low
- pll_locked  in  1  raw PLL lock, asynchronous, active-high
- rst_out  out  CHANNELS  per-domain reset, active-high
- ready  out  1  high when all channels are released
- rst_cause  out  2  last reset cause: 00 external, 01 button, 10 PLL loss, 11 reserved

## Operation
- btn_n and pll_locked each pass through a 2-flop synchroniser, giving btn_s and lock_s.
- cause = reset | btn_press | ~lock_s.
  - btn_press = ~btn_s, or the debounced equivalent when the macro is enabled.
- States:
  - HOLD: all rst_out=1, ready=0. hold_cnt clears to 0 on any cycle where cause=1, otherwise increments. When hold_cnt==2^HOLD_W-1 and cause=0, go to RELEASE: rst_out[0]<=0, gap_cnt<=0, idx<=1. If CHANNELS==1, go straight to RUN with ready<=1 on the same edge.
  - RELEASE: gap_cnt increments. When gap_cnt==STAGE_GAP-1: rst_out[idx]<=0, gap_cnt<=0, idx++. The edge that releases channel CHANNELS-1 also moves to RUN and sets ready<=1.
  - RUN: holds until cause.
- Any cause in RELEASE or RUN: on the next edge, state<=HOLD, all rst_out<=1, ready<=0, all counters<=0.
  - rst_cause latches on the same edge with priority: reset(00) > PLL loss(10) > button(01).
  - In HOLD, rst_cause updates on every cycle where cause=1, using the same priority.
- Released channels never reassert individually; reassertion is always all channels together.
- Reset values (reset=1): state=HOLD, rst_out all 1, ready=0, rst_cause=00, hold_cnt=gap_cnt=0, idx=0, synchroniser flops=0 (this reads as "button pressed, PLL unlocked").
- Counters must not wrap. hold_cnt saturates by leaving HOLD; gap_cnt is bounded by STAGE_GAP.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Pin-to-cause latency is 2 cycles (synchroniser), plus debounce when enabled.
- rst_out[0] falls exactly 2^HOLD_W edges after the first edge at which cause is sampled 0.
- rst_out[k] falls k*STAGE_GAP edges after rst_out[0] falls. ready rises together with rst_out[CHANNELS-1].
- Reassertion takes 1 edge after cause is sampled 1. Unsynchronised reset input: 1 cycle. Raw pins: 3 cycles.
- A cause lasting a single cycle mid-HOLD restarts the hold time from zero.

## Configuration
- RESET_SEQ_DEBOUNCE_EN defined:
  - btn_s feeds a debouncer; the debounced level changes only after btn_s differs from it for 2^DEB_W consecutive cycles.
  - Press and release are both debounced.
  - The debouncer resets to "released".
- Not defined:
  - btn_press=~btn_s directly; a 1-cycle low glitch causes a full reset sequence.
  - DEB_W is ignored.

## Structure
- Package reset_seq_pkg:
  - state enum {HOLD, RELEASE, RUN}.
  - Cause codes CAUSE_EXT=2'b00, CAUSE_BTN=2'b01, CAUSE_PLL=2'b10.
- Sub-module btn_debounce: synchroniser plus optional debouncer for btn_n. The pll_locked synchroniser stays inline.

## Test plan
- Power-on with defaults: reset high for 3 cycles, pll_locked=1, btn_n=1. rst_out[0] falls 64 cycles after the first cause-free edge, rst_out[1] falls 16 cycles later, ready=1 with it, rst_cause=00.
- In RUN, pll_locked drops for 1 cycle: all rst_out=1 three cycles after the pin change, ready=0, rst_cause=10. The full 64+16 sequence repeats after lock returns.
- reset and a PLL loss arrive together with the button pressed: rst_cause=00.
- Reset mid-RELEASE (after rst_out[0]=0, before rst_out[1]): both outputs are 1 on the next edge and the sequence restarts from zero hold.
- CHANNELS=4, STAGE_GAP=1, HOLD_W=3: releases at edges 8, 9, 10, 11 after the cause clears; ready rises at 11.
- With RESET_SEQ_DEBOUNCE_EN and DEB_W=4: a 10-cycle btn_n pulse causes no reset; a 20-cycle press resets with rst_cause=01. Without the macro, the 10-cycle pulse resets.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding and reset-cause codes for the reset sequencer.
package reset_seq_pkg;
  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_e;
  localparam logic [1:0] CAUSE_EXT = 2'b00;
  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_PLL = 2'b10;
  function automatic logic [1:0] cause_code(input logic ext, input logic pll_loss);
    return ext ? CAUSE_EXT : pll_loss ? CAUSE_PLL : CAUSE_BTN;
  endfunction
endpackage

// File: rtl/reset_seq_btn_debounce.sv
// btn_debounce: 2-flop synchroniser for the reset button plus optional debouncer.
// Debouncer is built only when RESET_SEQ_DEBOUNCE_EN is defined.
module btn_debounce #(
  parameter int unsigned DEB_W = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_n_i,
  output logic press_o
);
  logic [1:0] sync_q;
  logic       btn_s;
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[0], btn_n_i};
  end
  assign btn_s = sync_q[1];
`ifdef RESET_SEQ_DEBOUNCE_EN
  logic             pressed_q;
  logic [DEB_W-1:0] cnt_q;
  logic             differ;
  // debounced level flips only after a full run of 2^DEB_W differing samples
  assign differ = (btn_s == pressed_q);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pressed_q <= 1'b0;
      cnt_q     <= '0;
    end else if (!differ) begin
      cnt_q     <= '0;
    end else if (&cnt_q) begin
      pressed_q <= ~pressed_q;
      cnt_q     <= '0;
    end else begin
      cnt_q     <= cnt_q + DEB_W'(1);
    end
  end
  assign press_o = pressed_q;
`else
  logic unused_deb_w;
  assign unused_deb_w = ^DEB_W;
  assign press_o = ~btn_s;
`endif
endmodule

// File: rtl/reset_seq.sv
// reset_seq: merges external reset, button and PLL lock; holds 2^HOLD_W cycles, then releases channels.
// Optional button debounce: define RESET_SEQ_DEBOUNCE_EN.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned HOLD_W    = 6,
  parameter int unsigned STAGE_GAP = 16,
  parameter int unsigned DEB_W     = 16
) (
  input  logic                clk50,
  input  logic                reset,
  input  logic                btn_n,
  input  logic                pll_locked,
  output logic [CHANNELS-1:0] rst_out,
  output logic                ready,
  output logic [1:0]          rst_cause
);
  localparam int unsigned GW = STAGE_GAP > 1 ? $clog2(STAGE_GAP) : 1;
  localparam int unsigned IW = $clog2(CHANNELS + 1);
  logic [1:0]          lock_q;
  logic                lock_s;
  logic                btn_press;
  logic                cause;
  state_e              state_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [GW-1:0]       gap_q;
  logic [IW-1:0]       idx_q;
  logic [CHANNELS-1:0] rst_q;
  logic                ready_q;
  logic [1:0]          cause_q;
  btn_debounce #(.DEB_W(DEB_W)) u_btn (
    .clk_i  (clk50),
    .rst_i  (reset),
    .btn_n_i(btn_n),
    .press_o(btn_press)
  );
  assign lock_s = lock_q[1];
  assign cause  = reset | btn_press | ~lock_s;
  always_ff @(posedge clk50) begin
    if (reset) begin
      lock_q  <= '0;
      state_q <= HOLD;
      hold_q  <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      cause_q <= CAUSE_EXT;
    end else begin
      lock_q <= {lock_q[0], pll_locked};
      if (cause) begin
        state_q <= HOLD;
        hold_q  <= '0;
        gap_q   <= '0;
        idx_q   <= '0;
        rst_q   <= '1;
        ready_q <= 1'b0;
        cause_q <= cause_code(reset, ~lock_s);
      end else begin
        case (state_q)
          HOLD: begin
            if (&hold_q) begin
              rst_q[0] <= 1'b0;
              gap_q    <= '0;
              idx_q    <= IW'(1);
              state_q  <= (CHANNELS == 1) ? RUN : RELEASE;
              ready_q  <= (CHANNELS == 1);
            end else begin
              hold_q <= hold_q + HOLD_W'(1);
            end
          end
          RELEASE: begin
            if (gap_q == GW'(STAGE_GAP - 1)) begin
              rst_q <= rst_q & ~(CHANNELS'(1) << idx_q);
              gap_q <= '0;
              idx_q <= idx_q + IW'(1);
              if (idx_q == IW'(CHANNELS - 1)) begin
                state_q <= RUN;
                ready_q <= 1'b1;
              end
            end else begin
              gap_q <= gap_q + GW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end
  assign rst_out   = rst_q;
  assign ready     = ready_q;
  assign rst_cause = cause_q;
endmodule
